// File: rtl/truth_table_sweeper_if.sv
// Connection bundle between the truth-table sweeper and the network it exercises.
// The sweeper takes the slave side; whoever commands the sweep and owns the network takes the master side.
interface truth_table_sweeper_if #(
    parameter int N_IN = 3
);
    logic                    start;
    logic                    abort;
    logic                    f_in;
    logic [N_IN-1:0]         vec_out;
    logic                    busy;
    logic                    done;
    logic [(1<<N_IN)-1:0]    result;
    logic [N_IN:0]           mismatch_cnt;
    logic                    pass;

    modport master (
        output start, abort, f_in,
        input  vec_out, busy, done, result, mismatch_cnt, pass
    );

    modport slave (
        input  start, abort, f_in,
        output vec_out, busy, done, result, mismatch_cnt, pass
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Exhaustive input sweeper for a small combinational network: applies each vector, waits SETTLE
// cycles, samples the network output and compares the captured truth table against EXPECTED.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | no sweep since reset or since an abort; waits for start
// S_SETTLE | current vector applied, settle counter running down to zero
// S_SAMPLE | one cycle; f_in captured for the current vector at its closing edge
// S_DONE   | sweep complete, result/mismatch_cnt/pass held until next start
module truth_table_sweeper #(
    parameter int                   N_IN     = 3,
    parameter int                   SETTLE   = 2,
    parameter logic [(1<<N_IN)-1:0] EXPECTED = 8'b0010_0010
) (
    input  logic                   clk,
    input  logic                   rst,
    truth_table_sweeper_if.slave   sw
);
    localparam int              N_VEC       = 1 << N_IN;
    localparam logic [7:0]      SETTLE_LOAD = 8'(SETTLE - 1);
    localparam logic [N_IN-1:0] LAST_VEC    = {N_IN{1'b1}};
    localparam logic [N_IN-1:0] VEC_ONE     = {{(N_IN-1){1'b0}}, 1'b1};
    localparam logic [N_IN:0]   CNT_ONE     = {{N_IN{1'b0}}, 1'b1};
    localparam logic [N_IN:0]   CNT_MAX     = {1'b1, {N_IN{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t        state;
    logic [7:0]    settle_cnt;
    logic          sample_miss;
    logic [N_IN:0] cnt_next;
    logic          sweeping;

    // Case-inequality so an X/Z network output counts as a mismatch in simulation.
    assign sample_miss = (sw.f_in !== EXPECTED[sw.vec_out]);
    assign sweeping    = (state == S_SETTLE) || (state == S_SAMPLE);

    always_comb begin
        cnt_next = sw.mismatch_cnt;
        if (sample_miss && (sw.mismatch_cnt != CNT_MAX)) begin
            cnt_next = sw.mismatch_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            settle_cnt      <= '0;
            sw.vec_out      <= '0;
            sw.busy         <= 1'b0;
            sw.done         <= 1'b0;
            sw.pass         <= 1'b0;
            sw.result       <= '0;
            sw.mismatch_cnt <= '0;
        end else if (sweeping && sw.abort) begin
            // Partial result and mismatch count are kept for post-mortem inspection.
            state      <= S_IDLE;
            sw.vec_out <= '0;
            sw.busy    <= 1'b0;
            sw.done    <= 1'b0;
            sw.pass    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (sw.start) begin
                        state           <= S_SETTLE;
                        settle_cnt      <= SETTLE_LOAD;
                        sw.vec_out      <= '0;
                        sw.busy         <= 1'b1;
                        sw.done         <= 1'b0;
                        sw.pass         <= 1'b0;
                        sw.result       <= '0;
                        sw.mismatch_cnt <= '0;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == 8'd0) begin
                        state <= S_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                S_SAMPLE: begin
                    sw.result[sw.vec_out] <= sw.f_in;
                    sw.mismatch_cnt       <= cnt_next;
                    if (sw.vec_out == LAST_VEC) begin
                        state      <= S_DONE;
                        sw.vec_out <= '0;
                        sw.busy    <= 1'b0;
                        sw.done    <= 1'b1;
                        sw.pass    <= (cnt_next == '0);
                    end else begin
                        state      <= S_SETTLE;
                        settle_cnt <= SETTLE_LOAD;
                        sw.vec_out <= sw.vec_out + VEC_ONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
